// File: rtl/writeback_unit_if.sv
// Bundle of signals between the write-back stage and its neighbours:
// execute result handshake, data-bus load return, register file write
// port, and the decode operand/hazard path.
//   master : execute / memory / decode side (drives *_i, observes *_o)
//   slave  : writeback_unit
interface writeback_unit_if #(
  parameter int unsigned REG_WIDTH      = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5
);
  logic                      Ex_Valid_i;
  logic                      Ex_Ready_o;
  logic [REG_ADDR_WIDTH-1:0] Ex_Rd_i;
  logic                      Ex_Wb_i;
  logic [REG_WIDTH-1:0]      Ex_Data_i;
  logic                      Ex_IsLoad_i;
  logic [2:0]                Ex_LoadType_i;
  logic [1:0]                Ex_ByteOff_i;
  logic                      Mem_Ack_i;
  logic [REG_WIDTH-1:0]      Mem_Data_i;
  logic                      Rf_We_o;
  logic [REG_ADDR_WIDTH-1:0] Rf_Rd_o;
  logic [REG_WIDTH-1:0]      Rf_Data_o;
  logic [REG_ADDR_WIDTH-1:0] Ra_Sel_i;
  logic [REG_ADDR_WIDTH-1:0] Rb_Sel_i;
  logic [REG_WIDTH-1:0]      Ra_i;
  logic [REG_WIDTH-1:0]      Rb_i;
  logic [REG_WIDTH-1:0]      Ra_o;
  logic [REG_WIDTH-1:0]      Rb_o;
  logic                      Raw_Hazard_o;
  logic                      Load_Busy_o;

  modport master (
    output Ex_Valid_i, Ex_Rd_i, Ex_Wb_i, Ex_Data_i, Ex_IsLoad_i,
           Ex_LoadType_i, Ex_ByteOff_i, Mem_Ack_i, Mem_Data_i,
           Ra_Sel_i, Rb_Sel_i, Ra_i, Rb_i,
    input  Ex_Ready_o, Rf_We_o, Rf_Rd_o, Rf_Data_o, Ra_o, Rb_o,
           Raw_Hazard_o, Load_Busy_o
  );

  modport slave (
    input  Ex_Valid_i, Ex_Rd_i, Ex_Wb_i, Ex_Data_i, Ex_IsLoad_i,
           Ex_LoadType_i, Ex_ByteOff_i, Mem_Ack_i, Mem_Data_i,
           Ra_Sel_i, Rb_Sel_i, Ra_i, Rb_i,
    output Ex_Ready_o, Rf_We_o, Rf_Rd_o, Rf_Data_o, Ra_o, Rb_o,
           Raw_Hazard_o, Load_Busy_o
  );
endinterface

// File: rtl/writeback_unit.sv
// Write-back stage of the Atom core. Accepts execute results over a
// valid/ready handshake, waits for load data, aligns/sign-extends loads
// and drives a registered register-file write. Reports RAW hazards to
// decode and, optionally, forwards the in-flight write onto operands.
// Ports:
//   Clk_i : clock, rising edge
//   Rst_i : synchronous active-high reset
//   bus   : writeback_unit_if.slave (execute, memory, rf write, decode)
// Build option:
//   WB_BYPASS_EN : forward Rf_Data_o onto Ra_o/Rb_o instead of stalling
//                  decode on a pending register-file write.
module writeback_unit #(
  parameter int unsigned REG_WIDTH      = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5
) (
  input logic           Clk_i,
  input logic           Rst_i,
  writeback_unit_if.slave bus
);

  typedef enum logic {IDLE, LOAD_WAIT} state_t;

  state_t                    state_q, state_d;
  logic [REG_ADDR_WIDTH-1:0] pend_rd_q, pend_rd_d;
  logic                      pend_wb_q, pend_wb_d;
  logic [2:0]                pend_type_q, pend_type_d;
  logic [1:0]                pend_off_q, pend_off_d;
  logic                      we_q, we_d;
  logic [REG_ADDR_WIDTH-1:0] rd_q, rd_d;
  logic [REG_WIDTH-1:0]      data_q, data_d;

  logic [7:0]                ld_byte;
  logic [15:0]               ld_half;
  logic [REG_WIDTH-1:0]      ld_data;
  logic                      load_hz;

  always_ff @(posedge Clk_i) begin
    if (Rst_i) begin
      state_q     <= IDLE;
      pend_rd_q   <= '0;
      pend_wb_q   <= 1'b0;
      pend_type_q <= '0;
      pend_off_q  <= '0;
      we_q        <= 1'b0;
      rd_q        <= '0;
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      pend_rd_q   <= pend_rd_d;
      pend_wb_q   <= pend_wb_d;
      pend_type_q <= pend_type_d;
      pend_off_q  <= pend_off_d;
      we_q        <= we_d;
      rd_q        <= rd_d;
      data_q      <= data_d;
    end
  end

  // Load alignment: halves ignore off[0]; undefined funct3 acts as LW.
  always_comb begin
    ld_byte = '0;
    case (pend_off_q)
      2'd0:    ld_byte = bus.Mem_Data_i[7:0];
      2'd1:    ld_byte = bus.Mem_Data_i[15:8];
      2'd2:    ld_byte = bus.Mem_Data_i[23:16];
      default: ld_byte = bus.Mem_Data_i[31:24];
    endcase
    ld_half = pend_off_q[1] ? bus.Mem_Data_i[31:16] : bus.Mem_Data_i[15:0];
    case (pend_type_q)
      3'b000:  ld_data = {{(REG_WIDTH-8){ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{(REG_WIDTH-16){ld_half[15]}}, ld_half};
      3'b100:  ld_data = {{(REG_WIDTH-8){1'b0}}, ld_byte};
      3'b101:  ld_data = {{(REG_WIDTH-16){1'b0}}, ld_half};
      default: ld_data = bus.Mem_Data_i;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    pend_rd_d   = pend_rd_q;
    pend_wb_d   = pend_wb_q;
    pend_type_d = pend_type_q;
    pend_off_d  = pend_off_q;
    we_d        = 1'b0;
    rd_d        = rd_q;
    data_d      = data_q;
    case (state_q)
      IDLE: begin
        if (bus.Ex_Valid_i) begin
          if (bus.Ex_IsLoad_i) begin
            pend_rd_d   = bus.Ex_Rd_i;
            pend_wb_d   = bus.Ex_Wb_i;
            pend_type_d = bus.Ex_LoadType_i;
            pend_off_d  = bus.Ex_ByteOff_i;
            state_d     = LOAD_WAIT;
          end else begin
            we_d   = bus.Ex_Wb_i && (bus.Ex_Rd_i != '0);
            rd_d   = bus.Ex_Rd_i;
            data_d = bus.Ex_Data_i;
          end
        end
      end
      LOAD_WAIT: begin
        if (bus.Mem_Ack_i) begin
          we_d    = pend_wb_q && (pend_rd_q != '0);
          rd_d    = pend_rd_q;
          data_d  = ld_data;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.Ex_Ready_o  = (state_q == IDLE);
  assign bus.Load_Busy_o = (state_q == LOAD_WAIT);
  assign bus.Rf_We_o     = we_q;
  assign bus.Rf_Rd_o     = rd_q;
  assign bus.Rf_Data_o   = data_q;

  assign load_hz = (state_q == LOAD_WAIT) && pend_wb_q && (pend_rd_q != '0) &&
                   ((pend_rd_q == bus.Ra_Sel_i) || (pend_rd_q == bus.Rb_Sel_i));

`ifdef WB_BYPASS_EN
  assign bus.Ra_o = (we_q && (rd_q == bus.Ra_Sel_i) && (bus.Ra_Sel_i != '0)) ? data_q : bus.Ra_i;
  assign bus.Rb_o = (we_q && (rd_q == bus.Rb_Sel_i) && (bus.Rb_Sel_i != '0)) ? data_q : bus.Rb_i;
  assign bus.Raw_Hazard_o = load_hz;
`else
  logic wr_hz;
  assign wr_hz = we_q && (rd_q != '0) &&
                 ((rd_q == bus.Ra_Sel_i) || (rd_q == bus.Rb_Sel_i));
  assign bus.Ra_o = bus.Ra_i;
  assign bus.Rb_o = bus.Rb_i;
  assign bus.Raw_Hazard_o = load_hz || wr_hz;
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit: expected register-file writes are
// queued when stimulus is driven and checked when Rf_We_o appears.
module tb_writeback_unit;

  logic Clk_i = 1'b0;
  logic Rst_i = 1'b1;
  always #5 Clk_i = ~Clk_i;

  writeback_unit_if #(.REG_WIDTH(32), .REG_ADDR_WIDTH(5)) bus ();

  writeback_unit #(.REG_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
    .Clk_i (Clk_i),
    .Rst_i (Rst_i),
    .bus   (bus.slave)
  );

  int unsigned errors = 0;
  int unsigned checks = 0;
  logic [36:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Write monitor: every Rf_We_o cycle must match the oldest queued write.
  always @(negedge Clk_i) begin
    if (bus.Rf_We_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("spurious_write", {27'd0, bus.Rf_Rd_o}, 32'hFFFF_FFFF);
      end else begin
        logic [36:0] e;
        e = exp_q.pop_front();
        check("wr_rd", {27'd0, bus.Rf_Rd_o}, {27'd0, e[36:32]});
        check("wr_data", bus.Rf_Data_o, e[31:0]);
      end
    end
  end

  task automatic send_alu(input logic [4:0] rd, input logic wb, input logic [31:0] d);
    @(negedge Clk_i);
    bus.Ex_Valid_i = 1'b1; bus.Ex_IsLoad_i = 1'b0;
    bus.Ex_Rd_i = rd; bus.Ex_Wb_i = wb; bus.Ex_Data_i = d;
    if (wb && rd != 5'd0) exp_q.push_back({rd, d});
    @(negedge Clk_i);
    bus.Ex_Valid_i = 1'b0;
  endtask

  task automatic do_load(input logic [4:0] rd, input logic wb, input logic [2:0] ty,
                         input logic [1:0] off, input logic [31:0] word,
                         input logic [31:0] exp, input int unsigned wait_cyc,
                         input logic chk_hz, input logic exp_hz);
    @(negedge Clk_i);
    bus.Ex_Valid_i = 1'b1; bus.Ex_IsLoad_i = 1'b1;
    bus.Ex_Rd_i = rd; bus.Ex_Wb_i = wb; bus.Ex_LoadType_i = ty;
    bus.Ex_ByteOff_i = off; bus.Ex_Data_i = 32'h5555_AAAA;
    @(negedge Clk_i);
    bus.Ex_Valid_i = 1'b0;
    for (int unsigned i = 0; i < wait_cyc; i++) begin
      if (chk_hz) begin
        check("wait_hazard", {31'd0, bus.Raw_Hazard_o}, {31'd0, exp_hz});
        check("wait_ready", {31'd0, bus.Ex_Ready_o}, 32'd0);
        check("wait_busy", {31'd0, bus.Load_Busy_o}, 32'd1);
      end
      @(negedge Clk_i);
    end
    bus.Mem_Ack_i = 1'b1; bus.Mem_Data_i = word;
    if (wb && rd != 5'd0) exp_q.push_back({rd, exp});
    @(negedge Clk_i);
    bus.Mem_Ack_i = 1'b0; bus.Mem_Data_i = 32'h0;
  endtask

  initial begin
    bus.Ex_Valid_i = 1'b0; bus.Ex_Rd_i = '0; bus.Ex_Wb_i = 1'b0;
    bus.Ex_Data_i = '0; bus.Ex_IsLoad_i = 1'b0; bus.Ex_LoadType_i = '0;
    bus.Ex_ByteOff_i = '0; bus.Mem_Ack_i = 1'b0; bus.Mem_Data_i = '0;
    bus.Ra_Sel_i = '0; bus.Rb_Sel_i = '0; bus.Ra_i = '0; bus.Rb_i = '0;

    // Reset held for two cycles
    @(negedge Clk_i);
    @(negedge Clk_i);
    check("rst_we", {31'd0, bus.Rf_We_o}, 32'd0);
    check("rst_rd", {27'd0, bus.Rf_Rd_o}, 32'd0);
    check("rst_data", bus.Rf_Data_o, 32'd0);
    check("rst_busy", {31'd0, bus.Load_Busy_o}, 32'd0);
    check("rst_ready", {31'd0, bus.Ex_Ready_o}, 32'd1);
    Rst_i = 1'b0;

    // ALU result, write visible one cycle after acceptance
    send_alu(5'd5, 1'b1, 32'hDEAD_BEEF);
    check("alu_we", {31'd0, bus.Rf_We_o}, 32'd1);
    check("alu_rd", {27'd0, bus.Rf_Rd_o}, 32'd5);
    check("alu_data", bus.Rf_Data_o, 32'hDEAD_BEEF);
    @(negedge Clk_i);
    check("alu_pulse", {31'd0, bus.Rf_We_o}, 32'd0);

    // Back-to-back ALU results
    bus.Ex_Valid_i = 1'b1; bus.Ex_IsLoad_i = 1'b0; bus.Ex_Wb_i = 1'b1;
    bus.Ex_Rd_i = 5'd10; bus.Ex_Data_i = 32'h0000_0A0A;
    exp_q.push_back({5'd10, 32'h0000_0A0A});
    @(negedge Clk_i);
    bus.Ex_Rd_i = 5'd11; bus.Ex_Data_i = 32'h0000_0B0B;
    exp_q.push_back({5'd11, 32'h0000_0B0B});
    @(negedge Clk_i);
    bus.Ex_Valid_i = 1'b0;
    check("b2b_we2", {31'd0, bus.Rf_We_o}, 32'd1);
    @(negedge Clk_i);

    // Load formatting
    do_load(5'd6, 1'b1, 3'b000, 2'd3, 32'h80FF_0000, 32'hFFFF_FF80, 1, 1'b0, 1'b0);
    do_load(5'd6, 1'b1, 3'b100, 2'd2, 32'h80FF_0000, 32'h0000_00FF, 2, 1'b0, 1'b0);
    do_load(5'd6, 1'b1, 3'b001, 2'd2, 32'h80FF_0000, 32'hFFFF_80FF, 1, 1'b0, 1'b0);
    do_load(5'd8, 1'b1, 3'b101, 2'd0, 32'h0000_8001, 32'h0000_8001, 1, 1'b0, 1'b0);
    do_load(5'd8, 1'b1, 3'b001, 2'd3, 32'h8123_4567, 32'hFFFF_8123, 1, 1'b0, 1'b0);
    do_load(5'd9, 1'b1, 3'b010, 2'd1, 32'h1234_5678, 32'h1234_5678, 1, 1'b0, 1'b0);
    do_load(5'd9, 1'b1, 3'b011, 2'd2, 32'hCAFE_F00D, 32'hCAFE_F00D, 1, 1'b0, 1'b0);
    // Ack in the first LOAD_WAIT cycle
    do_load(5'd12, 1'b1, 3'b000, 2'd1, 32'h0000_7F00, 32'h0000_007F, 0, 1'b0, 1'b0);
    check("ready_after_load", {31'd0, bus.Ex_Ready_o}, 32'd1);
    @(negedge Clk_i);

    // RAW hazard while load to x7 is outstanding
    bus.Ra_Sel_i = 5'd7;
    do_load(5'd7, 1'b1, 3'b010, 2'd0, 32'h7777_0007, 32'h7777_0007, 4, 1'b1, 1'b1);
    @(negedge Clk_i);
    check("hz_clear", {31'd0, bus.Raw_Hazard_o}, 32'd0);
    check("hz_ready", {31'd0, bus.Ex_Ready_o}, 32'd1);
    bus.Ra_Sel_i = 5'd0; bus.Rb_Sel_i = 5'd0;
    do_load(5'd0, 1'b1, 3'b010, 2'd0, 32'h1111_1111, 32'h1111_1111, 2, 1'b1, 1'b0);
    @(negedge Clk_i);

    // Suppressed writes
    send_alu(5'd0, 1'b1, 32'h0BAD_0BAD);
    check("x0_no_we", {31'd0, bus.Rf_We_o}, 32'd0);
    send_alu(5'd9, 1'b0, 32'h0BAD_0BAD);
    check("nowb_no_we", {31'd0, bus.Rf_We_o}, 32'd0);
    bus.Mem_Ack_i = 1'b1; bus.Mem_Data_i = 32'hFFFF_FFFF;
    @(negedge Clk_i);
    bus.Mem_Ack_i = 1'b0;
    @(negedge Clk_i);
    check("stray_ack_no_we", {31'd0, bus.Rf_We_o}, 32'd0);

    // Reset during LOAD_WAIT discards the load
    bus.Ex_Valid_i = 1'b1; bus.Ex_IsLoad_i = 1'b1; bus.Ex_Rd_i = 5'd4;
    bus.Ex_Wb_i = 1'b1; bus.Ex_LoadType_i = 3'b010;
    @(negedge Clk_i);
    bus.Ex_Valid_i = 1'b0;
    check("busy_before_rst", {31'd0, bus.Load_Busy_o}, 32'd1);
    Rst_i = 1'b1;
    @(negedge Clk_i);
    Rst_i = 1'b0;
    check("busy_after_rst", {31'd0, bus.Load_Busy_o}, 32'd0);
    bus.Mem_Ack_i = 1'b1; bus.Mem_Data_i = 32'h4444_4444;
    @(negedge Clk_i);
    bus.Mem_Ack_i = 1'b0;
    check("late_ack_no_we", {31'd0, bus.Rf_We_o}, 32'd0);
    check("late_ack_busy", {31'd0, bus.Load_Busy_o}, 32'd0);

    // Write-pending path: bypass or stall
    bus.Rb_Sel_i = 5'd3; bus.Rb_i = 32'h0; bus.Ra_Sel_i = 5'd0; bus.Ra_i = 32'h0000_00AA;
    send_alu(5'd3, 1'b1, 32'h0000_1234);
    check("ra_passthru", bus.Ra_o, 32'h0000_00AA);
`ifdef WB_BYPASS_EN
    check("rb_bypass", bus.Rb_o, 32'h0000_1234);
    check("hz_bypass", {31'd0, bus.Raw_Hazard_o}, 32'd0);
`else
    check("rb_nobypass", bus.Rb_o, 32'h0);
    check("hz_nobypass", {31'd0, bus.Raw_Hazard_o}, 32'd1);
`endif
    @(negedge Clk_i);
    check("hz_after_write", {31'd0, bus.Raw_Hazard_o}, 32'd0);
    @(negedge Clk_i);

    check("queue_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
